// File: rtl/slow_memory_lat.sv
// Line-wide single-port memory model with programmable response latency,
// request abort, read/write conflict flag and saturating statistics counters.
module slow_memory_lat #(
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err_rw,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0]       CNT_INIT = 8'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0]      wdata_q, wdata_d;
    logic [LINE_W-1:0]      rdata_q, rdata_d;
    logic                   op_wr_q, op_wr_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic                   req, resp_entry;

    // Contents are not reset; a bench may preload them directly.
    logic [LINE_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Address bits above the index alias onto the same line.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        op_wr_d  = op_wr_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        req      = mem_read | mem_write;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_wdata;
                    op_wr_d = mem_write;
                    cnt_d   = CNT_INIT;
                    if (mem_read && mem_write) err_d = 1'b1;
                    if (LATENCY == 1) state_d = RESP;
                    else              state_d = WAIT;
                end
            end
            WAIT: begin
                // A dropped request wins even on the final countdown edge.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // _d operands are used so the LATENCY=1 IDLE->RESP path sees fresh values.
        resp_entry = (state_d == RESP) && (state_q != RESP);
        ready_d    = resp_entry;
        if (resp_entry) begin
            if (op_wr_d) begin
                if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                rdata_d = mem[idx_d];
                if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            op_wr_q  <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            op_wr_q  <= op_wr_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // rst_n gate keeps a held LATENCY=1 write from committing during reset.
    always_ff @(posedge clk) begin
        if (rst_n && resp_entry && op_wr_d) mem[idx_d] <= wdata_d;
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign err_rw    = err_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_slow_memory_lat.sv
// Bench for slow_memory_lat: table vectors, hand-written corner sequences and
// random traffic against an associative-array model of the line store.
module tb_slow_memory_lat;

    localparam int LA = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_rd, a_wr, a_ready, a_busy, a_err;
    logic [27:0]  a_addr;
    logic [127:0] a_wd, a_rdata;
    logic [15:0]  a_rdc, a_wrc;

    logic         b_rd, b_wr, b_ready, b_busy, b_err;
    logic [7:0]   b_addr;
    logic [31:0]  b_wd, b_rdata;
    logic [1:0]   b_rdc, b_wrc;

    slow_memory_lat #(.LINE_W(128), .ADDR_W(28), .DEPTH_LOG2(10), .LATENCY(LA), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr),
        .mem_addr(a_addr), .mem_wdata(a_wd), .mem_rdata(a_rdata), .mem_ready(a_ready),
        .busy(a_busy), .err_rw(a_err), .rd_count(a_rdc), .wr_count(a_wrc));

    slow_memory_lat #(.LINE_W(32), .ADDR_W(8), .DEPTH_LOG2(4), .LATENCY(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr),
        .mem_addr(b_addr), .mem_wdata(b_wd), .mem_rdata(b_rdata), .mem_ready(b_ready),
        .busy(b_busy), .err_rw(b_err), .rd_count(b_rdc), .wr_count(b_wrc));

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: stored lines by index, last read line, op tallies.
    logic [127:0] mdl [int];
    logic [127:0] mdl_last = '0;
    int           mdl_rd = 0;
    int           mdl_wr = 0;
    bit           mdl_err = 1'b0;

    typedef struct {
        bit           rd;
        bit           wr;
        bit           scr;
        int           abort_at;
        logic [27:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_a_state();
        chk("a rdata", a_rdata, mdl_last);
        chk("a rd_count", 128'(a_rdc), 128'(mdl_rd));
        chk("a wr_count", 128'(a_wrc), 128'(mdl_wr));
        chk("a err_rw", 128'(a_err), 128'(mdl_err));
    endtask

    // Called at a negedge with DUT A idle; acceptance is the next posedge.
    task automatic txn_a(input bit rd, input bit wr, input logic [27:0] addr,
                         input logic [127:0] wd, input bit scr, input int abort_at,
                         output logic [127:0] got);
        bit bad = 1'b0;
        int idx = int'(addr[9:0]);
        bit exp_rdy, exp_busy;
        got = '0;
        a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd;
        for (int k = 1; k <= LA + 1; k++) begin
            @(negedge clk);
            exp_rdy  = (abort_at == 0) && (k == LA);
            exp_busy = (abort_at == 0) ? (k <= LA) : (k <= abort_at);
            if (a_ready !== exp_rdy || a_busy !== exp_busy) bad = 1'b1;
            if (k == LA) got = a_rdata;
            if (k == abort_at || k == LA) begin
                a_rd = 1'b0; a_wr = 1'b0;
            end else if (scr && k < LA) begin
                a_addr = 28'($urandom);
                a_wd   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        chk("a ready/busy timing", 128'(bad), 128'(0));
        if (abort_at == 0) begin
            if (rd && wr) mdl_err = 1'b1;
            if (wr) begin
                mdl[idx] = wd;
                mdl_wr++;
            end else begin
                mdl_last = mdl[idx];
                mdl_rd++;
            end
        end
        chk_a_state();
    endtask

    initial begin
        logic [127:0] got;
        bit           bad;
        int           r, idx;
        logic [27:0]  ad;

        a_rd = 0; a_wr = 0; a_addr = '0; a_wd = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wd = '0;

        tbl.push_back('{1'b0, 1'b1, 1'b0, 0, 28'h5,     {16{8'hA5}}, 128'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 28'h5,     128'h0,      {16{8'hA5}}});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 0, 28'h3FF,   128'hDEADBEEF, 128'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 28'h3FF,   128'h0,      128'hDEADBEEF});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 28'h400,   {4{32'hC0FFEE11}}, 128'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 0, 28'h0,     128'h0,      {4{32'hC0FFEE11}}});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 28'h7,     {8{16'h5A5A}}, 128'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 28'hC07,   128'h0,      {8{16'h5A5A}}});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2, 28'h5,     128'h0,      128'h0});

        // Reset state of both instances.
        @(negedge clk); @(negedge clk);
        chk_a_state();
        chk("a ready reset", 128'(a_ready), 128'(0));
        chk("a busy reset", 128'(a_busy), 128'(0));
        chk("b reset outputs", {b_rdata, b_ready, b_busy, b_err, b_rdc, b_wrc}, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            txn_a(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].scr, tbl[i].abort_at, got);
            if (tbl[i].rd && !tbl[i].wr && tbl[i].abort_at == 0)
                chk($sformatf("table[%0d] rdata", i), got, tbl[i].exp);
        end

        // Read held across two transactions: RESP->IDLE edge must not re-accept.
        bad = 1'b0;
        a_rd = 1'b1; a_addr = 28'h3FF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (a_ready !== (k == LA || k == 2 * LA + 1)) bad = 1'b1;
            if (a_busy !== !(k == LA + 1 || k == 2 * LA + 2)) bad = 1'b1;
            if (k == 2 * LA + 1) a_rd = 1'b0;
        end
        chk("back-to-back spacing", 128'(bad), 128'(0));
        mdl_rd += 2;
        mdl_last = 128'hDEADBEEF;
        chk_a_state();

        // Reset in the middle of a write: line 5 must keep its old contents.
        a_wr = 1'b1; a_addr = 28'h5; a_wd = {4{32'h0BADF00D}};
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-write reset outputs",
            {a_rdata[31:0], 16'(a_rdc), 16'(a_wrc), 1'(a_ready), 1'(a_busy), 1'(a_err)}, 128'(0));
        a_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_rd = 0; mdl_wr = 0; mdl_err = 1'b0; mdl_last = '0;
        @(negedge clk);
        chk_a_state();
        txn_a(1'b1, 1'b0, 28'h5, 128'h0, 1'b0, 0, got);
        chk("line kept after reset", got, {16{8'hA5}});

        // Random traffic over 16 lines with random aliasing upper bits.
        for (int i = 0; i < 30; i++) begin
            r   = $urandom_range(0, 9);
            ad  = {18'($urandom), 10'($urandom_range(0, 15))};
            idx = int'(ad[9:0]);
            if (r < 4 || !mdl.exists(idx))
                txn_a(1'b0, 1'b1, ad, {$urandom(), $urandom(), $urandom(), $urandom()}, r[0], 0, got);
            else if (r < 8)
                txn_a(1'b1, 1'b0, ad, 128'h0, r[0], 0, got);
            else if (r == 8)
                txn_a(1'b1, 1'b1, ad, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 0, got);
            else
                txn_a(1'b1, 1'b0, ad, 128'h0, 1'b0, $urandom_range(1, LA - 1), got);
        end

        // LATENCY=1, CNT_W=2 instance: next-cycle ready, aliasing, saturation.
        b_wr = 1'b1; b_addr = 8'h03; b_wd = 32'h1234_5678;
        @(negedge clk);
        chk("b write ready", 128'(b_ready), 128'(1));
        b_wr = 1'b0;
        @(negedge clk);
        chk("b ready drop", 128'(b_ready), 128'(0));
        chk("b wr_count", 128'(b_wrc), 128'(1));
        for (int i = 1; i <= 5; i++) begin
            b_rd = 1'b1; b_addr = 8'h13;
            @(negedge clk);
            chk("b read ready", 128'(b_ready), 128'(1));
            chk("b alias rdata", 128'(b_rdata), 128'h1234_5678);
            b_rd = 1'b0;
            @(negedge clk);
            chk("b idle after resp", 128'({b_ready, b_busy}), 128'(0));
            chk("b rd_count sat", 128'(b_rdc), 128'((i > 3) ? 3 : i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/slow_memory_lat.md
Name: slow_memory_lat

Overview:
- Parametrised successor to the fixed slow-memory model used behind the I- and D-caches.
- Single-port line-wide memory with programmable response latency, configurable line/address width and depth.
- Adds asynchronous reset, request abort, illegal-request flagging, and saturating read/write transaction counters for bench statistics.
- Instantiated once per cache port (instruction and data) between CHIP and the TestBed.

Parameters:
LINE_W, 128, data line width in bits
ADDR_W, 28, line address width (byte address bits [31:4])
DEPTH_LOG2, 10, log2 of stored lines; index = mem_addr[DEPTH_LOG2-1:0]
LATENCY, 8, cycles from request acceptance to mem_ready; legal range 1..255
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  read request, held until mem_ready
mem_write  in  1  write request, held until mem_ready
mem_addr  in  ADDR_W  line address
mem_wdata  in  LINE_W  write line
mem_rdata  out  LINE_W  read line, valid while mem_ready on a read
mem_ready  out  1  one-cycle completion pulse
busy  out  1  high in WAIT and RESP
err_rw  out  1  sticky: read and write seen together at acceptance
rd_count  out  CNT_W  completed reads, saturating
wr_count  out  CNT_W  completed writes, saturating

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: mem_ready=0, mem_rdata=0, busy=0, err_rw=0, rd_count=0, wr_count=0, state=IDLE, latency counter=0.
- Array contents are not reset. Loaded by $readmemb on the array; the array is named mem.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with mem_read|mem_write=1, accept the request.
  - Latch addr index, wdata and op (write has priority if both are high; err_rw set to 1, sticky until reset).
  - Load cnt=LATENCY-1 and go to WAIT, or directly to RESP if LATENCY=1.
- WAIT:
  - Decrement cnt each edge. Leave for RESP on the edge where cnt==1.
  - If mem_read and mem_write are both 0 at any WAIT edge: abort to IDLE. No write, no counter update, no ready.
  - Changes to addr, wdata or op after acceptance are ignored.
- Entering RESP (registered):
  - mem_ready=1.
  - Write: array[idx] <= latched wdata; wr_count increments.
  - Read: mem_rdata <= array[idx]; rd_count increments.
- Latency: mem_ready is high exactly LATENCY cycles after the accepting edge, for exactly one cycle.
- RESP: next edge -> IDLE, mem_ready=0. The request is not sampled on that edge, so at least one cycle separates mem_ready from the next acceptance.
- mem_rdata holds its last read value between reads and is unchanged by writes.
- Address wrap: upper mem_addr bits above DEPTH_LOG2 are ignored (aliasing).
- Counters saturate at 2^CNT_W-1.
- Reset mid-transaction: immediate return to IDLE. A pending write is discarded; outputs take reset values.
- Read-after-write to the same line returns the new data, since the write commits at the RESP entry edge.

Test Plan:
1. LATENCY=4. Preload line 5=0x...A5. Read addr 5 accepted at edge T -> mem_ready=1 only in cycle T+4, mem_rdata=0x...A5, rd_count=1.
2. Write 0xDEADBEEF to addr 0x3FF, then read 0x3FF -> rdata=0xDEADBEEF, wr_count=1, rd_count=1. Second acceptance occurs no earlier than 2 cycles after the first ready.
3. DEPTH_LOG2=10: write to addr 0x400, read addr 0 -> same data (wrap). mem_addr changed during WAIT has no effect.
4. Read and write both high at acceptance -> write performed, err_rw=1 and stays 1 across later clean transactions.
5. Drop mem_read 2 cycles after acceptance -> no mem_ready, rd_count unchanged, busy=0 next cycle. Assert rst_n=0 mid-write -> line unchanged, all outputs 0.
6. CNT_W=2: five reads -> rd_count stays 3. LATENCY=1: ready in the cycle after acceptance.
